// File: rtl/bcd_to_binary_seq.sv
// Sequential reverse double-dabble: three BCD digits (2-bit hundreds) to 8-bit binary.
// Handshake is start/busy/done. ovf flags values above 255 and err flags bad digits.
module bcd_to_binary_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [1:0] hundreds,
    output logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [9:0]  bcd_reg;
    logic [7:0]  bin_acc_reg;
    logic [2:0]  cnt_reg;
    logic        err_pend_reg;
    logic        done_reg;
    logic [7:0]  bin_reg;
    logic        ovf_reg;
    logic        err_reg;

    logic        accept;
    logic        digit_bad;
    logic [17:0] shifted;
    logic [9:0]  bcd_corr;

    // The cycle that presents done still counts as busy, so accepting is held
    // off until it has passed.
    assign accept    = (state_reg == IDLE) && !done_reg && start;
    assign digit_bad = (ones > 4'd9) || (tens > 4'd9);

    assign shifted        = {bcd_reg, bin_acc_reg} >> 1;
    assign bcd_corr[9:8]  = shifted[17:16];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_digit_fix
            logic [3:0] digit;
            assign digit = shifted[8 + 4*gi +: 4];
            assign bcd_corr[4*gi +: 4] = (digit >= 4'd8) ? (digit - 4'd3) : digit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = digit_bad ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg      <= '0;
            bin_acc_reg  <= '0;
            cnt_reg      <= '0;
            err_pend_reg <= 1'b0;
            done_reg     <= 1'b0;
            bin_reg      <= '0;
            ovf_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bcd_reg      <= {hundreds, tens, ones};
                        bin_acc_reg  <= '0;
                        cnt_reg      <= '0;
                        ovf_reg      <= 1'b0;
                        err_reg      <= 1'b0;
                        err_pend_reg <= digit_bad;
                    end
                end
                SHIFT: begin
                    bcd_reg     <= bcd_corr;
                    bin_acc_reg <= shifted[7:0];
                    cnt_reg     <= cnt_reg + 3'd1;
                end
                DONE: begin
                    // Any BCD left after eight shifts means the value needed a ninth bit.
                    bin_reg <= bin_acc_reg;
                    ovf_reg <= (bcd_reg != 10'd0) && !err_pend_reg;
                    err_reg <= err_pend_reg;
                end
                default: ;
            endcase
        end
    end

    assign bin  = bin_reg;
    assign ovf  = ovf_reg;
    assign err  = err_reg;
    assign done = done_reg;
    assign busy = (state_reg != IDLE) || done_reg;

endmodule
